// File: rtl/prince_axis_pkg.sv
// rtl/prince_axis_pkg.sv - shared widths, FSM states and request-beat selection for prince_axis_host
package prince_axis_pkg;

  localparam int DATA_SIZE = 64;
  localparam int KEY_SIZE  = 2 * DATA_SIZE;

  // Position of each beat inside the request frame
  localparam logic [1:0] BEAT_K0 = 2'd0;
  localparam logic [1:0] BEAT_K1 = 2'd1;
  localparam logic [1:0] BEAT_PT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_K0,
    ST_SEND_K1,
    ST_SEND_PT,
    ST_WAIT_RSP,
    ST_DRAIN
  } state_t;

  // Request frame order: key high half, key low half, then the data block
  function automatic logic [DATA_SIZE-1:0] req_beat(
    input logic [KEY_SIZE-1:0]  k,
    input logic [DATA_SIZE-1:0] d,
    input logic [1:0]           idx
  );
    case (idx)
      BEAT_K0: req_beat = k[KEY_SIZE-1:DATA_SIZE];
      BEAT_K1: req_beat = k[DATA_SIZE-1:0];
      default: req_beat = d;
    endcase
  endfunction

endpackage

// File: rtl/prince_axis_host.sv
// rtl/prince_axis_host.sv - host endpoint: sends key/data as a 3-beat frame, collects the 1-beat result
module prince_axis_host
  import prince_axis_pkg::*;
#(
  parameter int DATA_SIZE      = 64,
  parameter int KEY_SIZE       = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  input  logic [KEY_SIZE-1:0]  key,
  input  logic [DATA_SIZE-1:0] din,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [DATA_SIZE-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  input  logic [DATA_SIZE-1:0] S_AXIS_TDATA,
  input  logic                 S_AXIS_TLAST
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [KEY_SIZE-1:0]  key_q;
  logic [DATA_SIZE-1:0] din_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 req_hs;
  logic                 rsp_hs;

  assign req_hs = M_AXIS_TVALID & M_AXIS_TREADY;
  assign rsp_hs = S_AXIS_TVALID & S_AXIS_TREADY;

  // Job sequencer: emits the request frame, collects or drains the response, and aborts a
  // silent wrapper after TIMEOUT_CYCLES response-wait cycles. All outputs are registers, so
  // each transition sets the values the next state presents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      dout          <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      S_AXIS_TREADY <= 1'b0;
      key_q         <= '0;
      din_q         <= '0;
      wait_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q         <= key;
            din_q         <= din;
            err           <= 1'b0;
            busy          <= 1'b1;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= req_beat(key, din, BEAT_K0);
            M_AXIS_TLAST  <= 1'b0;
            state         <= ST_SEND_K0;
          end
        end
        // TDATA/TLAST only change on a handshake, so a stalled beat is held as-is
        ST_SEND_K0: begin
          if (req_hs) begin
            M_AXIS_TDATA <= req_beat(key_q, din_q, BEAT_K1);
            state        <= ST_SEND_K1;
          end
        end
        ST_SEND_K1: begin
          if (req_hs) begin
            M_AXIS_TDATA <= req_beat(key_q, din_q, BEAT_PT);
            M_AXIS_TLAST <= 1'b1;
            state        <= ST_SEND_PT;
          end
        end
        ST_SEND_PT: begin
          if (req_hs) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            S_AXIS_TREADY <= 1'b1;
            wait_cnt      <= '0;
            state         <= ST_WAIT_RSP;
          end
        end
        // An accepted beat takes priority over a timeout expiring on the same edge
        ST_WAIT_RSP: begin
          if (rsp_hs) begin
            dout <= S_AXIS_TDATA;
            if (S_AXIS_TLAST) begin
              done          <= 1'b1;
              busy          <= 1'b0;
              S_AXIS_TREADY <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              err   <= 1'b1;
              state <= ST_DRAIN;
            end
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt      <= CNT_MAX;
            err           <= 1'b1;
            done          <= 1'b1;
            busy          <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
            state         <= ST_IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        // Overlong response: swallow beats up to the frame end, keep the first beat's data
        ST_DRAIN: begin
          if (rsp_hs && S_AXIS_TLAST) begin
            done          <= 1'b1;
            busy          <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_axis_host.sv
// tb/tb_prince_axis_host.sv - randomized scoreboard bench for prince_axis_host
`timescale 1ns/1ps
module tb_prince_axis_host;

  localparam int TO = 16;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] dout;
    logic        err;
    int          lat;
  } res_t;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          start;
  logic [127:0]  key;
  logic [63:0]   din;
  logic          busy;
  logic          done;
  logic          err;
  logic [63:0]   dout;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic [63:0]   M_AXIS_TDATA;
  logic          M_AXIS_TLAST;
  logic          S_AXIS_TVALID;
  logic          S_AXIS_TREADY;
  logic [63:0]   S_AXIS_TDATA;
  logic          S_AXIS_TLAST;

  beat_t       req_q[$];
  res_t        res_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          t_pt = 0;
  int          tready_mode = 0;
  logic        rsp_pending = 1'b0;
  logic [63:0] model_dout = 64'd0;
  logic [63:0] rsp_data[8];
  int          rsp_n = 0;

  logic        stall_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic        prev_done = 1'b0;
  logic [63:0] st_data = 64'd0;
  logic        st_last = 1'b0;

  prince_axis_host #(
    .DATA_SIZE(64),
    .KEY_SIZE(128),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .start(start),
    .key(key),
    .din(din),
    .busy(busy),
    .done(done),
    .err(err),
    .dout(dout),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TLAST(S_AXIS_TLAST)
  );

  always #5 ACLK = ~ACLK;

  initial forever begin
    @(posedge ACLK);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Request-side ready: 0 = always ready, 1 = two stall cycles per beat, 2 = random
  initial begin
    int   ph;
    logic hs;
    logic wv;
    ph = 0;
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      hs = M_AXIS_TVALID && M_AXIS_TREADY;
      wv = M_AXIS_TVALID;
      @(posedge ACLK);
      #1;
      if (hs || !wv) ph = 0;
      else ph = ph + 1;
      case (tready_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = (ph >= 2);
        default: M_AXIS_TREADY = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: request beats, stall stability and job results against the scoreboard queues
  initial begin
    beat_t b;
    res_t  e;
    forever begin
      @(negedge ACLK);
      if (stall_prev && !rst_prev) begin
        check("stall_tvalid", M_AXIS_TVALID, 1);
        check("stall_tdata", M_AXIS_TDATA, st_data);
        check("stall_tlast", M_AXIS_TLAST, st_last);
      end
      if (!ARESET && M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
        if (req_q.size() == 0) begin
          check("unexpected_req_beat", 1, 0);
        end else begin
          b = req_q.pop_front();
          check("req_tdata", M_AXIS_TDATA, b.data);
          check("req_tlast", M_AXIS_TLAST, b.last);
          if (b.last) t_pt = cyc + 1;
        end
      end
      if (done === 1'b1) begin
        check("done_one_cycle", prev_done, 0);
        check("busy_at_done", busy, 0);
        check("s_tready_at_done", S_AXIS_TREADY, 0);
        check("done_before_frame_end", rsp_pending, 0);
        if (res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = res_q.pop_front();
          check("dout", dout, e.dout);
          check("err", err, e.err);
          if (e.lat >= 0) check("done_latency", cyc - t_pt, e.lat);
        end
      end
      stall_prev = (M_AXIS_TVALID === 1'b1) && (M_AXIS_TREADY === 1'b0);
      st_data    = M_AXIS_TDATA;
      st_last    = M_AXIS_TLAST;
      prev_done  = (done === 1'b1);
      rst_prev   = (ARESET === 1'b1);
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge ACLK);
      if (done === 1'b1) ok = 1'b1;
    end
    check("done_seen", ok, 1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_m_tvalid", M_AXIS_TVALID, 0);
    check("rst_m_tlast", M_AXIS_TLAST, 0);
    check("rst_m_tdata", M_AXIS_TDATA, 0);
    check("rst_s_tready", S_AXIS_TREADY, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_dout", dout, 0);
  endtask

  // One job: queue the expected frame and result, then play the responder from rsp_data/rsp_n
  task automatic run_job(input logic [127:0] k, input logic [63:0] d, input int delay,
                         input int mode, input bit ghost, input bit b2b);
    beat_t b;
    res_t  e;
    bit    ok;
    tready_mode = mode;
    b.data = k[127:64]; b.last = 1'b0; req_q.push_back(b);
    b.data = k[63:0];   b.last = 1'b0; req_q.push_back(b);
    b.data = d;         b.last = 1'b1; req_q.push_back(b);
    if (rsp_n == 0) begin
      e.dout = model_dout;
      e.err  = 1'b1;
      e.lat  = TO;
    end else begin
      e.dout = rsp_data[0];
      e.err  = (rsp_n > 1);
      e.lat  = (rsp_n == 1 && delay == 0 && !ghost) ? 1 : -1;
      model_dout = rsp_data[0];
    end
    res_q.push_back(e);

    start = 1'b1;
    key   = k;
    din   = d;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("tvalid_after_start", M_AXIS_TVALID, 1);
    check("err_cleared_on_start", err, 0);

    if (ghost) begin
      @(posedge ACLK);
      #1;
      start = 1'b1;
      key   = ~k;
      din   = ~d;
      @(posedge ACLK);
      #1;
      start = 1'b0;
    end

    rsp_pending = (rsp_n > 0);
    repeat (delay) begin
      @(posedge ACLK);
      #1;
    end
    for (int i = 0; i < rsp_n; i++) begin
      ok = 1'b0;
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = rsp_data[i];
      S_AXIS_TLAST  = (i == rsp_n - 1);
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge ACLK);
        ok = (S_AXIS_TREADY === 1'b1);
        @(posedge ACLK);
        #1;
      end
      S_AXIS_TVALID = 1'b0;
      check("rsp_beat_accepted", ok, 1);
      if (i == rsp_n - 1) rsp_pending = 1'b0;
      else if ($urandom_range(0, 1) == 1) begin
        @(posedge ACLK);
        #1;
      end
    end
    if (!b2b || rsp_n == 0) wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    ARESET = 1'b1;
    start = 1'b0;
    key = '0;
    din = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA = '0;
    S_AXIS_TLAST = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check_reset_values();
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // Nominal job
    rsp_n = 1;
    rsp_data[0] = 64'hDEADBEEF00C0FFEE;
    run_job(128'h0011223344556677_8899AABBCCDDEEFF, 64'h0123456789ABCDEF, 0, 0, 1'b0, 1'b0);

    // Backpressure 0,0,1 per beat
    rsp_n = 1;
    rsp_data[0] = 64'h0F1E2D3C4B5A6978;
    run_job(128'hA5A5A5A5_11112222_33334444_55556666, 64'hCAFEF00D12345678, 0, 1, 1'b0, 1'b0);

    // Overlong response: first beat kept, err set, done only after the TLAST beat
    rsp_n = 3;
    rsp_data[0] = 64'h1;
    rsp_data[1] = 64'h2;
    rsp_data[2] = 64'h3;
    run_job(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64'h5555AAAA5555AAAA, 0, 0, 1'b0, 1'b0);

    // Silent wrapper: timeout, dout keeps the previous result
    rsp_n = 0;
    run_job(128'hFFFF0000FFFF0000_1234123412341234, 64'h0BADC0DE0BADC0DE, 0, 0, 1'b0, 1'b0);

    // Reset after beat1 handshakes, then a fresh job
    tready_mode = 0;
    b.data = 64'h1111111111111111; b.last = 1'b0; req_q.push_back(b);
    b.data = 64'h2222222222222222; b.last = 1'b0; req_q.push_back(b);
    start = 1'b1;
    key   = 128'h1111111111111111_2222222222222222;
    din   = 64'h3333333333333333;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    @(posedge ACLK);
    #1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check_reset_values();
    check("req_beats_before_reset", req_q.size(), 0);
    model_dout = 64'd0;
    @(posedge ACLK);
    #1;
    rsp_n = 1;
    rsp_data[0] = 64'h7777666655554444;
    run_job(128'h0011223344556677_8899AABBCCDDEEFF, 64'h0123456789ABCDEF, 0, 0, 1'b0, 1'b0);

    // Start pulse during SEND_K1 must not disturb the frame
    rsp_n = 1;
    rsp_data[0] = 64'h9999888877776666;
    run_job(128'hBEEFBEEFBEEFBEEF_C0DEC0DEC0DEC0DE, 64'h0102030405060708, 0, 0, 1'b1, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      logic [127:0] k;
      logic [63:0]  d;
      int           sc;
      k  = {$urandom, $urandom, $urandom, $urandom};
      d  = {$urandom, $urandom};
      sc = $urandom_range(0, 19);
      if (sc < 12) begin
        rsp_n = 1;
        rsp_data[0] = {$urandom, $urandom};
      end else if (sc < 17) begin
        rsp_n = $urandom_range(2, 5);
        for (int i = 0; i < rsp_n; i++) rsp_data[i] = {$urandom, $urandom};
      end else begin
        rsp_n = 0;
      end
      run_job(k, d, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6),
              $urandom_range(0, 2), ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
    end

    repeat (30) @(posedge ACLK);
    #1;
    check("req_queue_drained", req_q.size(), 0);
    check("res_queue_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
